// File: rtl/serial_bcd_xs3_codec.sv
// -----------------------------------------------------------------------------
// serial_bcd_xs3_codec
//
// Bit-serial, multi-digit BCD <-> Excess-3 converter. Bits arrive LSB-first,
// four per digit, least-significant digit first. Each digit has 3 added to it
// (mode 0, BCD->XS3) or subtracted from it (mode 1, XS3->BCD), modulo 16. The
// converted bit leaves in the same cycle as the input bit (Mealy output).
// The direction is latched on the first bit of every frame.
//
// Optional feature: define SER_XS3_ERRCHK_EN to build the digit legality
// checker (digit_err / frame_err). Without it both flags are tied to 0.
//
// Parameters:
//   DIGITS       digits per frame (>= 1); a frame is 4*DIGITS valid bits
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   x            serial input bit, qualified by x_valid
//   x_valid      input qualifier; idle cycles freeze all state
//   frame_start  with x_valid, forces this bit to be bit 0 of digit 0
//   mode         0 = BCD->XS3, 1 = XS3->BCD; sampled on a frame's first bit
//   z            converted bit, combinational from state, x and mode
//   z_valid      copy of x_valid
//   digit_done   registered pulse after the 4th bit of each digit
//   digit_err    registered, valid with digit_done: input digit was illegal
//   frame_done   registered pulse after the last bit of the last digit
//   frame_err    registered sticky OR of digit_err over the current frame
// -----------------------------------------------------------------------------
module serial_bcd_xs3_codec #(
    parameter int DIGITS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic x,
    input  logic x_valid,
    input  logic frame_start,
    input  logic mode,
    output logic z,
    output logic z_valid,
    output logic digit_done,
    output logic digit_err,
    output logic frame_done,
    output logic frame_err
);

    localparam int              DW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0]   LAST_DIGIT = DW'(DIGITS - 1);

    logic [1:0]    bit_cnt_q,   bit_cnt_d;
    logic [DW-1:0] digit_cnt_q, digit_cnt_d;
    logic          cb_q,        cb_d;
    logic          m_q,         m_d;
    logic          digit_done_q, digit_done_d;
    logic          frame_done_q, frame_done_d;

    logic          first_bit;
    logic [1:0]    bit_idx;
    logic [DW-1:0] digit_idx;
    logic          m_eff;
    logic          k;
    logic          c;
    logic          cb_next;

    // Datapath for the current bit. A frame_start re-targets this bit to
    // bit 0 of digit 0, so the position used here may differ from the counters.
    always_comb begin
        first_bit = x_valid & (frame_start | ((bit_cnt_q == 2'd0) && (digit_cnt_q == '0)));
        bit_idx   = frame_start ? 2'd0 : bit_cnt_q;
        digit_idx = frame_start ? '0   : digit_cnt_q;
        // The first bit of a frame already converts in the newly sampled mode.
        m_eff     = first_bit ? mode : m_q;
        // Constant 3 fed LSB-first: 1,1,0,0.
        k         = ~bit_idx[1];
        // Carry/borrow never crosses a digit boundary.
        c         = (bit_idx == 2'd0) ? 1'b0 : cb_q;
        z         = x ^ k ^ c;
        if (m_eff) begin
            cb_next = (~x & k) | (~x & c) | (k & c);
        end else begin
            cb_next = (x & k) | (x & c) | (k & c);
        end
    end

    // NOTE: every signal gets a default before the ifs so no latch is inferred.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        digit_cnt_d  = digit_cnt_q;
        cb_d         = cb_q;
        m_d          = m_q;
        digit_done_d = 1'b0;
        frame_done_d = 1'b0;
        if (x_valid) begin
            cb_d = cb_next;
            m_d  = m_eff;
            if (bit_idx == 2'd3) begin
                bit_cnt_d    = 2'd0;
                digit_done_d = 1'b1;
                if (digit_idx == LAST_DIGIT) begin
                    digit_cnt_d  = '0;
                    frame_done_d = 1'b1;
                end else begin
                    digit_cnt_d = digit_idx + 1'b1;
                end
            end else begin
                bit_cnt_d   = bit_idx + 2'd1;
                digit_cnt_d = digit_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_q    <= 2'd0;
            digit_cnt_q  <= '0;
            cb_q         <= 1'b0;
            m_q          <= 1'b0;
            digit_done_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            digit_cnt_q  <= digit_cnt_d;
            cb_q         <= cb_d;
            m_q          <= m_d;
            digit_done_q <= digit_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign z_valid    = x_valid;
    assign digit_done = digit_done_q;
    assign frame_done = frame_done_q;

`ifdef SER_XS3_ERRCHK_EN
    logic [2:0] h_q, h_d;
    logic [3:0] v;
    logic       illegal;
    logic       digit_err_q, digit_err_d;
    logic       frame_err_q, frame_err_d;

    // h holds the three previous bits of the digit, newest at the top, so the
    // complete input digit at bit 3 is {x, h}.
    always_comb begin
        h_d         = h_q;
        digit_err_d = 1'b0;
        frame_err_d = frame_err_q;
        v           = {x, h_q};
        illegal     = m_eff ? ((v < 4'd3) || (v > 4'd12)) : (v > 4'd9);
        if (x_valid) begin
            h_d = {x, h_q[2:1]};
            if (first_bit) begin
                frame_err_d = 1'b0;
            end
            if (bit_idx == 2'd3) begin
                digit_err_d = illegal;
                frame_err_d = frame_err_q | illegal;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q         <= 3'd0;
            digit_err_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            h_q         <= h_d;
            digit_err_q <= digit_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign digit_err = digit_err_q;
    assign frame_err = frame_err_q;
`else
    assign digit_err = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: doc/serial_bcd_xs3_codec.md
# serial_bcd_xs3_codec

Bit-serial, multi-digit BCD↔Excess-3 converter with a selectable direction per frame. It is the parametrised successor to the single-digit serial BCD-to-Excess-3 state machine, and sits between a serial BCD source and serial consumers in the lab datapath. Input bits stream LSB-first, four bits per digit, least-significant digit first. Output bits are produced in the same cycle (Mealy).

## Interface
- `DIGITS`, default 4: digits per frame, ≥1; frame length is 4·DIGITS valid bits.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `x`, in, 1: serial data bit, sampled when `x_valid`=1.
- `x_valid`, in, 1: qualifies `x`. Idle cycles (0) freeze all state.
- `frame_start`, in, 1: with `x_valid`=1, forces this bit to be bit 0 of digit 0.
- `mode`, in, 1: 0 = BCD→XS3 (add 3); 1 = XS3→BCD (subtract 3). Sampled only on the first bit of a frame.
- `z`, out, 1: converted bit, combinational from state, `x` and `mode`.
- `z_valid`, out, 1: equals `x_valid`.
- `digit_done`, out, 1: registered one-cycle pulse after the 4th bit of each digit.
- `digit_err`, out, 1: registered, valid with `digit_done`; high if the input digit was illegal.
- `frame_done`, out, 1: registered one-cycle pulse after the last bit of digit DIGITS−1.
- `frame_err`, out, 1: registered sticky OR of `digit_err` over the current frame; cleared on the first bit of the next frame.

## Operation
- State: `bit_cnt` (2 b, 0..3), `digit_cnt` (⌈log2 DIGITS⌉ b, min 1), carry/borrow `cb`, latched mode `m`, input history `h[2:0]`.
- Constant K = 3, fed LSB-first: bit 0 = 1, bit 1 = 1, bits 2 and 3 = 0.
- Effective carry `c` is 0 when `bit_cnt`=0, else `cb`.
- Add mode (m=0):
  - z = x ^ k ^ c
  - cb_next = x&k | x&c | k&c
- Subtract mode (m=1):
  - z = x ^ k ^ c
  - cb_next = ~x&k | ~x&c | k&c
- Results are modulo 16 per digit. Carry/borrow out of bit 3 is discarded and never crosses into the next digit. So BCD 13 → XS3 0, and XS3 1 → 14.
- On each valid bit, `bit_cnt` increments. On wrap 3→0, `digit_cnt` increments; at DIGITS−1 it wraps to 0 and `frame_done` pulses.
- First bit of a frame is `frame_start`=1, or `bit_cnt`=0 with `digit_cnt`=0. On that bit:
  - `m` ← `mode`, and that same bit already uses the new mode.
  - `frame_err` is cleared.
- `frame_start` mid-frame: the partial digit/frame is abandoned with no `digit_done`/`frame_done` pulse. The counters restart so this bit is bit 0 of digit 0.
- Legality of the input digit v (4 bits, assembled from `h` plus the current x at bit 3):
  - BCD mode: v ≤ 9.
  - XS3 mode: 3 ≤ v ≤ 12.
  - An illegal digit still converts arithmetically (mod 16); only the flags report it.
- Reset (any time, including mid-frame) forces all counters, `cb`, `m`, `h` and all registered outputs to 0. The next valid bit starts a new frame.

## Timing
- `z` and `z_valid`: zero latency, same cycle as `x`.
- `digit_done`/`digit_err`: the cycle after the valid bit that completes the digit, regardless of `x_valid` in that cycle.
- `frame_done`: the same cycle as the final `digit_done`. `frame_err` updates in that cycle to include the last digit.
- Back-to-back frames need no idle cycle.
- `x_valid` gaps are allowed anywhere; pulses are emitted only after valid bits.
- Reset values: `z_valid`=0 (follows `x_valid`), `digit_done`=`digit_err`=`frame_done`=`frame_err`=0. `z` is combinational from reset state: x ^ 1 when `x_valid`.

## Configuration
- `SER_XS3_ERRCHK_EN` defined: legality check, `h` register, `digit_err` and `frame_err` are implemented as above.
- Not defined: `h` and the checker are removed; `digit_err` and `frame_err` are tied to 0. Conversion and `digit_done`/`frame_done` are unchanged.

## Test plan
- DIGITS=4, mode=0, input BCD 0x0429, continuous valid → z = 0x375C. `frame_done` pulses once; `frame_err`=0.
- mode=1, input XS3 0x375C → z = 0x0429. Then mode=0 with 0x9999 back-to-back → z = 0xCCCC, and each frame uses its own latched mode.
- mode=0, digit 0xA among legal digits → that digit's z = 0xD, `digit_err`=1 for that digit only, `frame_err`=1 until the next frame's first bit. Repeat without `SER_XS3_ERRCHK_EN` → both flags stay 0.
- Random `x_valid` gaps, including a gap right after the final bit → same z sequence as continuous input; `frame_done` one cycle after the last valid bit.
- `frame_start` asserted on bit 2 of digit 1 → no `frame_done` for the aborted frame. The new frame converts correctly from that bit.
- `reset` pulsed mid-digit → all outputs 0 immediately (asynchronous). The next frame 0x0000 → z = 0x3333.
